// File: rtl/key_debounce.sv
// key_debounce: push-button conditioning front end.
// Per key: 2-flop sync, stability debounce, press/release/repeat strobes.
module key_debounce #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys,
    output logic [N_KEYS-1:0] held,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ?
                        $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST =
        RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REPEAT
    } rep_state_t;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        logic            r_sync1;
        logic            r_sync2;
        logic [DW-1:0]   r_dcnt;
        logic            r_held;
        logic            r_press;
        logic            r_rel;
        logic            w_diff;
        logic            w_toggle;
        logic            w_rise;
        logic            w_fall;
        rep_state_t      r_state;
        rep_state_t      w_state_nxt;
        logic [RW-1:0]   r_rcnt;
        logic [RW-1:0]   w_rcnt_nxt;
        logic            r_rep;
        logic            w_rep_nxt;

        // Two-flop synchroniser; reset value means "released".
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= keys[g];
                r_sync2 <= r_sync1;
            end
        end

        // Level-change detection against the debounced state.
        always_comb begin
            w_diff   = (~r_sync2) != r_held;
            w_toggle = w_diff && (r_dcnt == DC_LAST);
            w_rise   = w_toggle && !r_held;
            w_fall   = w_toggle && r_held;
        end

        // Stability counter, debounced level and edge strobes.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dcnt  <= '0;
                r_held  <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                if (!w_diff) begin
                    r_dcnt <= '0;
                end else if (w_toggle) begin
                    r_dcnt <= '0;
                    r_held <= ~r_held;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
                r_press <= w_rise;
                r_rel   <= w_fall;
            end
        end

        // Auto-repeat state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_rcnt  <= '0;
                r_rep   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_rcnt  <= w_rcnt_nxt;
                r_rep   <= w_rep_nxt;
            end
        end

        // Auto-repeat next state; a falling edge always wins.
        always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            w_rep_nxt   = 1'b0;
            if (w_fall) begin
                w_state_nxt = S_IDLE;
                w_rcnt_nxt  = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_rise && (REPEAT_DELAY != 0)) begin
                            w_state_nxt = S_WAIT;
                            w_rcnt_nxt  = '0;
                        end
                    end
                    S_WAIT: begin
                        if (r_rcnt == RD_LAST) begin
                            w_rep_nxt   = 1'b1;
                            w_state_nxt = S_REPEAT;
                            w_rcnt_nxt  = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (r_rcnt == RP_LAST) begin
                            w_rep_nxt  = 1'b1;
                            w_rcnt_nxt = '0;
                        end else begin
                            w_rcnt_nxt = r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_rcnt_nxt  = '0;
                    end
                endcase
            end
        end

        assign held[g]          = r_held;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_rel;
        assign repeat_pulse[g]  = r_rep;
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed + random bench for key_debounce.
// Windowed-history / elapsed-time model checked every cycle.
module tb_key_debounce;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [1:0] keys = 2'b11;

    logic [1:0] held_a, press_a, rel_a, rep_a;
    logic [1:0] held_b, press_b, rel_b, rep_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .N_KEYS(2), .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut_a (
        .clk(clk), .rst(rst), .keys(keys),
        .held(held_a), .press_pulse(press_a),
        .release_pulse(rel_a), .repeat_pulse(rep_a)
    );

    key_debounce #(
        .N_KEYS(2), .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
    ) u_dut_b (
        .clk(clk), .rst(rst), .keys(keys),
        .held(held_b), .press_pulse(press_b),
        .release_pulse(rel_b), .repeat_pulse(rep_b)
    );

    task automatic chk(input string nm, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: history of sampled key levels and edge times.
    bit q [2][$];
    bit m_held [2];
    bit m_press [2];
    bit m_rel [2];
    bit m_rep [2][2];
    int pe [2];
    int en;

    initial begin
        en = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                en = 0;
                for (int k = 0; k < 2; k++) begin
                    q[k].delete();
                    q[k].push_back(1'b1);
                    q[k].push_back(1'b1);
                    m_held[k]  = 1'b0;
                    m_press[k] = 1'b0;
                    m_rel[k]   = 1'b0;
                    pe[k]      = 0;
                    m_rep[0][k] = 1'b0;
                    m_rep[1][k] = 1'b0;
                end
            end else begin
                en++;
                for (int k = 0; k < 2; k++) begin
                    bit tg;
                    int sz;
                    q[k].push_back(keys[k]);
                    if (q[k].size() > DC + 4) void'(q[k].pop_front());
                    sz = q[k].size();
                    // sync2 used at this edge is q[sz-3]; the last DC
                    // of them must all show the opposite of held.
                    tg = (sz >= DC + 2);
                    for (int j = sz - 2 - DC; j <= sz - 3; j++)
                        if (j >= 0 && q[k][j] != m_held[k]) tg = 1'b0;
                    m_press[k] = tg && !m_held[k];
                    m_rel[k]   = tg && m_held[k];
                    if (tg) m_held[k] = !m_held[k];
                    if (m_press[k]) pe[k] = en;
                    for (int d = 0; d < 2; d++) begin
                        int rd;
                        int dd;
                        rd = (d == 0) ? RD : 0;
                        dd = en - pe[k];
                        m_rep[d][k] = m_held[k] && !m_press[k] &&
                            (rd != 0) &&
                            (dd == rd ||
                             (dd > rd && ((dd - rd) % RP) == 0));
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("held_a", held_a, {m_held[1], m_held[0]});
        chk("press_a", press_a, {m_press[1], m_press[0]});
        chk("rel_a", rel_a, {m_rel[1], m_rel[0]});
        chk("rep_a", rep_a, {m_rep[0][1], m_rep[0][0]});
        chk("held_b", held_b, {m_held[1], m_held[0]});
        chk("press_b", press_b, {m_press[1], m_press[0]});
        chk("rel_b", rel_b, {m_rel[1], m_rel[0]});
        chk("rep_b", rep_b, {m_rep[1][1], m_rep[1][0]});
    end

    bit pat [16] = '{0, 0, 0, 1, 0, 0, 0, 1,
                     1, 1, 1, 1, 1, 1, 1, 1};
    int exp_rep [7] = '{10, 13, 16, 19, 22, 25, 28};
    int rq [$];
    int bad;
    int cnt;
    int np, nr, nrep;
    int seg [2];

    initial begin
        tick(2);
        chk("rst_held", held_a, 2'b00);
        chk("rst_press", press_a, 2'b00);
        chk("rst_rep", rep_a, 2'b00);
        #2 rst = 1'b0;
        tick(3);

        // 1: clean press on key0
        keys = 2'b10;
        tick(5);
        chk("t1_pre_press", press_a, 2'b00);
        chk("t1_pre_held", held_a, 2'b00);
        tick(1);
        chk("t1_held", held_a, 2'b01);
        chk("t1_press", press_a, 2'b01);
        chk("t1_rel", rel_a, 2'b00);
        tick(1);
        chk("t1_press_once", press_a, 2'b00);
        chk("t1_held_stay", held_a, 2'b01);
        keys = 2'b11;
        tick(8);
        chk("t1_released", held_a, 2'b00);

        // 2: bounce rejection on key0
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            keys[0] = pat[i];
            tick(1);
            if (held_a[0] || press_a[0] || rel_a[0]) bad++;
        end
        chk_i("t2_bounce", bad, 0);

        // 3: auto-repeat on key1
        keys = 2'b01;
        tick(6);
        chk("t3_press", press_a, 2'b10);
        rq.delete();
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (rep_a[1]) rq.push_back(i);
        end
        chk_i("t3_rep_cnt", rq.size(), 7);
        for (int i = 0; i < 7; i++)
            chk_i("t3_rep_at", (i < rq.size()) ? rq[i] : -1, exp_rep[i]);
        keys = 2'b11;
        tick(5);
        chk("t3_rel_early", rel_a, 2'b00);
        tick(1);
        chk("t3_rel", rel_a, 2'b10);
        chk("t3_no_rep", rep_a, 2'b00);
        tick(8);

        // 4: simultaneous keys
        keys = 2'b00;
        tick(6);
        chk("t4_press", press_a, 2'b11);
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 19) keys = 2'b01;
            tick(1);
            if (rep_a[1]) cnt++;
            if (i == 24) begin
                chk("t4_rel", rel_a, 2'b01);
                chk("t4_held", held_a, 2'b10);
            end
        end
        chk_i("t4_rep1_cnt", cnt, 7);
        keys = 2'b11;
        tick(10);

        // 5: reset while key0 is repeating
        keys = 2'b10;
        tick(6);
        chk("t5_press", press_a, 2'b01);
        tick(15);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_held", held_a, 2'b00);
        chk("t5_rst_rep", rep_a | press_a | rel_a, 2'b00);
        chk("t5_rst_b", held_b | rep_b | press_b | rel_b, 2'b00);
        @(negedge clk);
        #2 rst = 1'b0;
        tick(5);
        chk("t5_pre_press", press_a, 2'b00);
        tick(1);
        chk("t5_repress", press_a, 2'b01);
        tick(9);
        chk("t5_pre_rep", rep_a, 2'b00);
        tick(1);
        chk("t5_rep", rep_a, 2'b01);
        keys = 2'b11;
        tick(10);

        // 6: repeat disabled instance
        np = 0; nr = 0; nrep = 0;
        keys = 2'b10;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            np += int'(press_b[0]);
            nr += int'(rel_b[0]);
            nrep += int'(rep_b[0]);
        end
        keys = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            np += int'(press_b[0]);
            nr += int'(rel_b[0]);
            nrep += int'(rep_b[0]);
        end
        chk_i("t6_press", np, 1);
        chk_i("t6_rep", nrep, 0);
        chk_i("t6_rel", nr, 1);

        // Random bouncing with long holds and occasional resets.
        seg[0] = 0;
        seg[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (seg[k] == 0) begin
                    keys[k] = 1'($urandom_range(0, 1));
                    seg[k] = ($urandom_range(0, 3) == 0) ?
                             int'($urandom_range(20, 40)) :
                             int'($urandom_range(1, 6));
                end
                seg[k]--;
            end
            tick(1);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #1;
                chk("rnd_rst", held_a | press_a | rel_a | rep_a, 2'b00);
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        keys = 2'b11;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
